fft_stream_adapter: RTL and testbench
=====================================

FFT_STREAM_ADAPTER -- requirements
Module: fft_stream_adapter

Interface
REQ-001 The block SHALL have parameter N, default 32, meaning FFT frame length in complex samples (power of two, >= 4).
REQ-002 The block SHALL have parameter word_size, default 16, meaning bits per real/imag component; one complex sample is word_size*2 bits.
REQ-003 The block SHALL have port clk  input  1  the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 The block SHALL have port s_valid  input  1  host sample stream valid.
REQ-006 The block SHALL have port s_data  input  word_size*2  host complex sample.
REQ-007 The block SHALL have port s_ready  output  1  adapter accepts s_data this cycle.
REQ-008 The block SHALL have port fft_input_valid  output  1  drives the core's input_valid.
REQ-009 The block SHALL have port fft_sample1, fft_sample2  output  word_size*2 each  drive the core's i_input_sample1/2.
REQ-010 The block SHALL have port fft_receiver_ready  output  1  drives the core's receiver_ready.
REQ-011 The block SHALL have port fft_output_valid  input  1  the core's output_valid.
REQ-012 The block SHALL have port fft_result1, fft_result2  input  word_size*2 each  the core's o_output_sample1/2.
REQ-013 The block SHALL have port m_valid  output  1, m_data  output  word_size*2, m_last  output  1  result stream; m_ready  input  1.
REQ-014 The block SHALL have port busy  output  1  high in any state other than FILL; proto_err  output  1  sticky protocol-error flag.

Function
REQ-015 The block SHALL implement states FILL -> SEND -> WAIT -> DRAIN -> FILL, using an N-entry input buffer and an N-entry output buffer.
REQ-016 FILL: s_ready SHALL be 1; a sample transfers when s_valid&&s_ready and is written to input index k = 0..N-1 in arrival order; s_valid gaps stall k.
REQ-017 On acceptance of sample N-1 the block SHALL enter SEND on the next cycle with s_ready=0.
REQ-018 SEND: the block SHALL assert fft_input_valid for exactly N/2 consecutive cycles; beat j carries fft_sample1=in[2j], fft_sample2=in[2j+1], j = 0..N/2-1, with no bubbles and no backpressure.
REQ-019 After beat N/2-1 the block SHALL enter WAIT; fft_input_valid SHALL be 0 and fft_sample1/2 SHALL hold their last value outside SEND.
REQ-020 WAIT: fft_receiver_ready SHALL be 1; each cycle with fft_output_valid=1 SHALL capture fft_result1 to out[2j] and fft_result2 to out[2j+1], j incrementing from 0.
REQ-021 On capture of beat N/2-1 the block SHALL enter DRAIN; fft_receiver_ready SHALL be 0 from the next cycle.
REQ-022 DRAIN: m_data SHALL present out[0..N-1] in order; m_valid and m_data SHALL be registered and stable until m_valid&&m_ready; m_last SHALL be 1 only with out[N-1].
REQ-023 After the m_last transfer the block SHALL return to FILL with s_ready=1 on the next cycle; the first output sample SHALL be offered no later than 2 cycles after entering DRAIN.
REQ-024 fft_output_valid=1 in any state other than WAIT SHALL be ignored for data and SHALL set proto_err, which remains 1 until reset.
REQ-025 Indices SHALL wrap only through the state transitions above; no index SHALL exceed N-1 or N/2-1.
REQ-026 A WAIT of unbounded length SHALL be permitted; the block SHALL NOT implement a timeout.

Reset
REQ-027 While reset=0 at a clock edge, the block SHALL enter FILL, clear all indices and proto_err, and drive s_ready=1 (from the first cycle after reset releases), fft_input_valid=0, fft_receiver_ready=0, m_valid=0, m_last=0, busy=0, fft_sample1/2=0, m_data=0.
REQ-028 Reset in any state, including mid-SEND or mid-DRAIN, SHALL abort the frame; buffer contents need not be cleared, and no stale sample SHALL be emitted afterwards.

Verification
REQ-029 N=32; feed s_data=0..31 with s_valid=1 continuously -> 16 contiguous fft_input_valid beats with (0,1),(2,3)..(30,31), starting 1 cycle after sample 31 is accepted.
REQ-030 In WAIT, return 16 beats with results (100+2j, 101+2j) and 3-cycle gaps -> m_data=100..131 in order; m_last only on 131; fft_receiver_ready falls the cycle after the last beat.
REQ-031 In DRAIN, hold m_ready=0 for 5 cycles, then toggle it -> m_data/m_valid stable while stalled; no sample lost or duplicated; s_ready=1 the cycle after the m_last transfer.
REQ-032 Assert reset=0 at SEND beat 7 -> all outputs at reset values next cycle; new frame 200..231 -> beats start at (200,201).
REQ-033 Pulse fft_output_valid during FILL -> proto_err=1 and sticky; out buffer unchanged; next frame is processed normally.
REQ-034 Random s_valid duty (~30%) over 3 back-to-back frames -> frame order and sample order preserved end-to-end against a reference model.

Source files
------------

// File: rtl/fft_stream_adapter.sv
// Frames a host sample stream into N/2 paired beats for an FFT core and re-serialises its results.
// Beat 0 one cycle after the last input; first result offered on entry to DRAIN; host/sink stall via s_ready/m_ready.
module fft_stream_adapter #(
  parameter int N         = 32,
  parameter int word_size = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_valid,
  input  logic [word_size*2-1:0] s_data,
  output logic                   s_ready,
  output logic                   fft_input_valid,
  output logic [word_size*2-1:0] fft_sample1,
  output logic [word_size*2-1:0] fft_sample2,
  output logic                   fft_receiver_ready,
  input  logic                   fft_output_valid,
  input  logic [word_size*2-1:0] fft_result1,
  input  logic [word_size*2-1:0] fft_result2,
  output logic                   m_valid,
  output logic [word_size*2-1:0] m_data,
  output logic                   m_last,
  input  logic                   m_ready,
  output logic                   busy,
  output logic                   proto_err
);
  localparam int KW = $clog2(N);
  localparam int JW = KW - 1;
  localparam int DW = word_size * 2;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);
  localparam logic [JW-1:0] J_LAST = JW'(N / 2 - 1);

  typedef enum logic [1:0] {FILL, SEND, WAIT, DRAIN} state_t;

  state_t        r_state;
  logic [DW-1:0] r_in  [N];
  logic [DW-1:0] r_out [N];
  logic [KW-1:0] r_k;
  logic [JW-1:0] r_j;
  logic          r_s_ready, r_fiv, r_rr, r_mv, r_ml, r_busy, r_perr;
  logic [DW-1:0] r_s1, r_s2, r_md;

  logic [KW-1:0] w_kn;
  logic [JW-1:0] w_jn;
  logic          w_s_fire, w_r_fire;

  assign w_kn     = r_k + KW'(1);
  assign w_jn     = r_j + JW'(1);
  assign w_s_fire = reset && (r_state == FILL) && s_valid && r_s_ready;
  assign w_r_fire = reset && (r_state == WAIT) && fft_output_valid;

  // Buffers are never reset: every entry is rewritten before it is read in a new frame.
  always_ff @(posedge clk) begin
    if (w_s_fire) r_in[r_k] <= s_data;
    if (w_r_fire) begin
      r_out[{r_j, 1'b0}] <= fft_result1;
      r_out[{r_j, 1'b1}] <= fft_result2;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= FILL;
      r_k       <= '0;
      r_j       <= '0;
      r_s_ready <= 1'b1;
      r_fiv     <= 1'b0;
      r_rr      <= 1'b0;
      r_mv      <= 1'b0;
      r_ml      <= 1'b0;
      r_busy    <= 1'b0;
      r_perr    <= 1'b0;
      r_s1      <= '0;
      r_s2      <= '0;
      r_md      <= '0;
    end else begin
      if (fft_output_valid && r_state != WAIT) r_perr <= 1'b1;
      case (r_state)
        FILL: if (w_s_fire) begin
          if (r_k == K_LAST) begin
            // Pair 0 is already buffered, so beat 0 goes out on the first SEND cycle.
            r_state   <= SEND;
            r_s_ready <= 1'b0;
            r_busy    <= 1'b1;
            r_k       <= '0;
            r_j       <= '0;
            r_fiv     <= 1'b1;
            r_s1      <= r_in[0];
            r_s2      <= r_in[1];
          end else begin
            r_k <= w_kn;
          end
        end
        SEND: begin
          if (r_j == J_LAST) begin
            r_state <= WAIT;
            r_fiv   <= 1'b0;
            r_rr    <= 1'b1;
            r_j     <= '0;
          end else begin
            r_j  <= w_jn;
            r_s1 <= r_in[{w_jn, 1'b0}];
            r_s2 <= r_in[{w_jn, 1'b1}];
          end
        end
        WAIT: if (fft_output_valid) begin
          if (r_j == J_LAST) begin
            r_state <= DRAIN;
            r_rr    <= 1'b0;
            r_j     <= '0;
            r_k     <= '0;
            r_mv    <= 1'b1;
            r_md    <= r_out[0];
            r_ml    <= 1'b0;
          end else begin
            r_j <= w_jn;
          end
        end
        DRAIN: if (m_ready) begin
          if (r_k == K_LAST) begin
            r_state   <= FILL;
            r_mv      <= 1'b0;
            r_ml      <= 1'b0;
            r_s_ready <= 1'b1;
            r_busy    <= 1'b0;
            r_k       <= '0;
          end else begin
            r_k  <= w_kn;
            r_md <= r_out[w_kn];
            r_ml <= (w_kn == K_LAST);
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign s_ready            = r_s_ready;
  assign fft_input_valid    = r_fiv;
  assign fft_sample1        = r_s1;
  assign fft_sample2        = r_s2;
  assign fft_receiver_ready = r_rr;
  assign m_valid            = r_mv;
  assign m_data             = r_md;
  assign m_last             = r_ml;
  assign busy               = r_busy;
  assign proto_err          = r_perr;
endmodule

// File: tb/tb_fft_stream_adapter.sv
// Directed bench for fft_stream_adapter: framing, result capture, drain stalls, reset abort, protocol error.
module tb_fft_stream_adapter;
  localparam int N  = 32;
  localparam int WS = 16;
  localparam int DW = WS * 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          fft_input_valid;
  logic [DW-1:0] fft_sample1, fft_sample2;
  logic          fft_receiver_ready;
  logic          fft_output_valid;
  logic [DW-1:0] fft_result1, fft_result2;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_ready;
  logic          busy;
  logic          proto_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fft_stream_adapter #(.N(N), .word_size(WS)) dut (
    .clk                (clk),
    .reset              (reset),
    .s_valid            (s_valid),
    .s_data             (s_data),
    .s_ready            (s_ready),
    .fft_input_valid    (fft_input_valid),
    .fft_sample1        (fft_sample1),
    .fft_sample2        (fft_sample2),
    .fft_receiver_ready (fft_receiver_ready),
    .fft_output_valid   (fft_output_valid),
    .fft_result1        (fft_result1),
    .fft_result2        (fft_result2),
    .m_valid            (m_valid),
    .m_data             (m_data),
    .m_last             (m_last),
    .m_ready            (m_ready),
    .busy               (busy),
    .proto_err          (proto_err)
  );

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_s_ready", DW'(s_ready), 1);
    chk("rst_fiv", DW'(fft_input_valid), 0);
    chk("rst_rr", DW'(fft_receiver_ready), 0);
    chk("rst_mv", DW'(m_valid), 0);
    chk("rst_ml", DW'(m_last), 0);
    chk("rst_busy", DW'(busy), 0);
    chk("rst_perr", DW'(proto_err), 0);
    chk("rst_s1", fft_sample1, 0);
    chk("rst_s2", fft_sample2, 0);
    chk("rst_md", m_data, 0);
  endtask

  // Push N samples base..base+N-1 with the given percentage valid duty.
  task automatic send_frame(input int base, input int duty);
    int k = 0;
    int c = 0;
    logic acc;
    while (k < N && c < 4000) begin
      s_data  = DW'(base + k);
      s_valid = (duty >= 100) || ($urandom_range(99) < duty);
      acc     = s_valid && s_ready;
      tick();
      if (acc) k++;
      c++;
    end
    s_valid = 1'b0;
    if (k < N) chk("fill_timeout", DW'(k), DW'(N));
  endtask

  task automatic check_beats(input int base, input int nbeats);
    for (int j = 0; j < nbeats; j++) begin
      chk("beat_vld", DW'(fft_input_valid), 1);
      chk("beat_s1", fft_sample1, DW'(base + 2 * j));
      chk("beat_s2", fft_sample2, DW'(base + 2 * j + 1));
      chk("beat_sready", DW'(s_ready), 0);
      tick();
    end
  endtask

  task automatic check_wait_entry(input int base);
    chk("wait_fiv", DW'(fft_input_valid), 0);
    chk("wait_rr", DW'(fft_receiver_ready), 1);
    chk("wait_s1_hold", fft_sample1, DW'(base + N - 2));
    chk("wait_s2_hold", fft_sample2, DW'(base + N - 1));
    chk("wait_busy", DW'(busy), 1);
  endtask

  task automatic return_results(input int rbase, input int gap);
    for (int j = 0; j < N / 2; j++) begin
      for (int g = 0; g < gap; g++) begin
        fft_output_valid = 1'b0;
        tick();
        chk("gap_rr", DW'(fft_receiver_ready), 1);
        chk("gap_mv", DW'(m_valid), 0);
      end
      fft_output_valid = 1'b1;
      fft_result1      = DW'(rbase + 2 * j);
      fft_result2      = DW'(rbase + 2 * j + 1);
      tick();
    end
    fft_output_valid = 1'b0;
    chk("drain_rr_low", DW'(fft_receiver_ready), 0);
    chk("drain_first_vld", DW'(m_valid), 1);
  endtask

  // mode 0: always ready; 1: stall 5 cycles then toggle; 2: random.
  task automatic drain(input int rbase, input int mode);
    int idx = 0;
    int c = 0;
    while (idx < N && c < 4000) begin
      chk("m_valid", DW'(m_valid), 1);
      chk("m_data", m_data, DW'(rbase + idx));
      chk("m_last", DW'(m_last), DW'(idx == N - 1));
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (c < 5) ? 1'b0 : c[0];
        default: m_ready = 1'($urandom_range(1));
      endcase
      tick();
      if (m_ready) idx++;
      c++;
    end
    m_ready = 1'b0;
    if (idx < N) chk("drain_timeout", DW'(idx), DW'(N));
    chk("post_s_ready", DW'(s_ready), 1);
    chk("post_mv", DW'(m_valid), 0);
    chk("post_busy", DW'(busy), 0);
  endtask

  initial begin
    reset = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    fft_output_valid = 1'b0; fft_result1 = '0; fft_result2 = '0;
    tick();
    tick();
    chk_reset_outputs();
    reset = 1'b1;
    tick();
    chk("rel_s_ready", DW'(s_ready), 1);

    // Contiguous frame, gapped results, stalled drain.
    send_frame(0, 100);
    check_beats(0, N / 2);
    check_wait_entry(0);
    return_results(100, 3);
    drain(100, 1);
    chk("perr_clean", DW'(proto_err), 0);

    // Abort at SEND beat 7, then a fresh frame.
    send_frame(500, 100);
    check_beats(500, 7);
    chk("abort_beat7", fft_sample1, DW'(514));
    reset = 1'b0;
    tick();
    chk_reset_outputs();
    reset = 1'b1;
    tick();
    send_frame(200, 100);
    check_beats(200, N / 2);
    check_wait_entry(200);
    return_results(1200, 0);
    drain(1200, 0);

    // Stray core output during FILL.
    fft_output_valid = 1'b1;
    fft_result1 = DW'(999);
    fft_result2 = DW'(998);
    tick();
    fft_output_valid = 1'b0;
    chk("perr_set", DW'(proto_err), 1);
    chk("perr_fill_sready", DW'(s_ready), 1);
    tick();
    tick();
    chk("perr_sticky", DW'(proto_err), 1);
    send_frame(40, 100);
    check_beats(40, N / 2);
    check_wait_entry(40);
    return_results(2000, 1);
    drain(2000, 0);
    chk("perr_still", DW'(proto_err), 1);

    // Three back-to-back frames at ~30% input duty; results tagged per frame.
    for (int f = 0; f < 3; f++) begin
      send_frame(3000 + 100 * f, 30);
      check_beats(3000 + 100 * f, N / 2);
      check_wait_entry(3000 + 100 * f);
      return_results(7000 + 100 * f, 2);
      drain(7000 + 100 * f, 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
